// File: rtl/isp_yuv444to422_pkg.sv
// Shared definitions for the YUV 4:4:4 -> 4:2:2 chroma subsampler and its neighbours.
package isp_yuv444to422_pkg;

  localparam int unsigned YUV422_DLY = 3;

  typedef struct packed {
    logic href;
    logic vsync;
  } sync_t;

  // Offset-binary chroma midpoint for a given component width.
  function automatic int unsigned chroma_mid(input int unsigned bits);
    return 32'(1) << (bits - 32'(1));
  endfunction

endpackage

// File: rtl/isp_sync_dly.sv
// Generic fixed-latency shift-register delay for sync and data lanes.
module isp_sync_dly #(
  parameter int unsigned DLY = 3,
  parameter int unsigned W   = 1
) (
  input  logic         pclk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [DLY];

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DLY); i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < int'(DLY); i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[DLY-1];

endmodule

// File: rtl/isp_yuv444to422.sv
// Horizontal chroma subsampler: YUV 4:4:4 in, Y + alternating U/V chroma lane out,
// fixed 3-pclk latency on every output.
module isp_yuv444to422
  import isp_yuv444to422_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 960,
  parameter bit          CHROMA_AVG = 1'b1
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            in_href,
  input  logic            in_vsync,
  input  logic [BITS-1:0] in_y,
  input  logic [BITS-1:0] in_u,
  input  logic [BITS-1:0] in_v,
  output logic            out_href,
  output logic            out_vsync,
  output logic [BITS-1:0] out_y,
  output logic [BITS-1:0] out_c
);

  if (BITS < 2 || WIDTH == 0 || HEIGHT == 0) begin : g_bad_param
    $error("isp_yuv444to422: unsupported parameter set");
  end

  sync_t           w_sync_in;
  sync_t           w_sync_out;
  logic [BITS-1:0] w_y_dly;

  logic            r_phase;
  logic            r1_href;
  logic            r1_odd;
  logic [BITS-1:0] r1_u;
  logic [BITS-1:0] r1_v;
  logic [BITS-1:0] r_even_v;
  logic [BITS-1:0] r_c2;
  logic [BITS-1:0] r_c3;

  logic [BITS:0]   w_u_sum;
  logic [BITS:0]   w_v_sum;
  logic [BITS-1:0] w_c;

  assign w_sync_in.href  = in_href;
  assign w_sync_in.vsync = in_vsync;

  isp_sync_dly #(.DLY(YUV422_DLY), .W($bits(sync_t))) u_sync_dly (
    .pclk  (pclk),
    .rst_n (rst_n),
    .i_d   (w_sync_in),
    .o_q   (w_sync_out)
  );

  isp_sync_dly #(.DLY(YUV422_DLY), .W(BITS)) u_y_dly (
    .pclk  (pclk),
    .rst_n (rst_n),
    .i_d   (in_y),
    .o_q   (w_y_dly)
  );

  // Even pixel sits in stage 1 while its odd partner is on the inputs;
  // the odd pixel pairs with the V saved from the even one.
  assign w_u_sum = {1'b0, r1_u} + {1'b0, in_u} + (BITS+1)'(1);
  assign w_v_sum = {1'b0, r_even_v} + {1'b0, r1_v} + (BITS+1)'(1);

  always_comb begin
    w_c = '0;
    if (r1_odd) begin
      w_c = CHROMA_AVG ? w_v_sum[BITS:1] : r1_v;
    end else if (in_href && CHROMA_AVG) begin
      w_c = w_u_sum[BITS:1];
    end else begin
      // Decimation, or an even pixel whose line ended before a partner arrived.
      w_c = r1_u;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= 1'b0;
      r1_href  <= 1'b0;
      r1_odd   <= 1'b0;
      r1_u     <= '0;
      r1_v     <= '0;
      r_even_v <= '0;
      r_c2     <= '0;
      r_c3     <= '0;
    end else begin
      r_phase <= in_href ? ~r_phase : 1'b0;
      r1_href <= in_href;
      r1_odd  <= in_href & r_phase;
      r1_u    <= in_u;
      r1_v    <= in_v;
      if (r1_href && !r1_odd) r_even_v <= r1_v;
      r_c2 <= r1_href ? w_c : '0;
      r_c3 <= r_c2;
    end
  end

  assign out_href  = w_sync_out.href;
  assign out_vsync = w_sync_out.vsync;
  assign out_y     = w_sync_out.href ? w_y_dly : '0;
  assign out_c     = w_sync_out.href ? r_c3 : '0;

endmodule

// File: tb/tb_isp_yuv444to422.sv
// Directed bench for isp_yuv444to422: averaging and decimation instances share one stimulus.
module tb_isp_yuv444to422;

  localparam int unsigned BITS = 8;

  logic            pclk = 1'b0;
  logic            rst_n;
  logic            in_href, in_vsync;
  logic [BITS-1:0] in_y, in_u, in_v;

  logic            a_href, a_vsync, d_href, d_vsync;
  logic [BITS-1:0] a_y, a_c, d_y, d_c;

  always #5 pclk = ~pclk;

  isp_yuv444to422 #(.BITS(BITS), .CHROMA_AVG(1'b1)) u_dut_avg (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .out_href(a_href), .out_vsync(a_vsync), .out_y(a_y), .out_c(a_c)
  );

  isp_yuv444to422 #(.BITS(BITS), .CHROMA_AVG(1'b0)) u_dut_dec (
    .pclk(pclk), .rst_n(rst_n), .in_href(in_href), .in_vsync(in_vsync),
    .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .out_href(d_href), .out_vsync(d_vsync), .out_y(d_y), .out_c(d_c)
  );

  typedef struct {
    logic            href;
    logic            vsync;
    logic [BITS-1:0] y, u, v;
    logic [BITS-1:0] c_avg, c_dec;
  } vec_t;

  vec_t tv[64];
  int   n_tv = 0;
  vec_t hist[3];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  function automatic vec_t px(input logic [7:0] u, v, ca, cd);
    vec_t r;
    r.href = 1'b1; r.vsync = 1'b0;
    r.y = 8'((step_no + n_tv) * 9 + 5);
    r.u = u; r.v = v; r.c_avg = ca; r.c_dec = cd;
    return r;
  endfunction

  function automatic vec_t idl(input logic vs);
    vec_t r;
    r.href = 1'b0; r.vsync = vs;
    r.y = 8'hAA; r.u = 8'h55; r.v = 8'h66; r.c_avg = '0; r.c_dec = '0;
    return r;
  endfunction

  task automatic add(input vec_t v);
    tv[n_tv] = v;
    n_tv++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at step %0d: got %0d expected %0d", name, step_no, act, exp);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 3; i++) hist[i] = idl(1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_href"},  32'(a_href),  0);
    chk({tag, "_vsync"}, 32'(a_vsync), 0);
    chk({tag, "_y"},     32'(a_y),     0);
    chk({tag, "_c"},     32'(a_c),     0);
    chk({tag, "_dc"},    32'(d_c),     0);
  endtask

  // Drive one cycle; outputs then reflect the vector applied two steps earlier (3 pclk latency).
  task automatic step(input vec_t v);
    in_href = v.href; in_vsync = v.vsync;
    in_y = v.y; in_u = v.u; in_v = v.v;
    @(posedge pclk); #1;
    step_no++;
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
    chk("href",    32'(a_href),  32'(hist[2].href));
    chk("vsync",   32'(a_vsync), 32'(hist[2].vsync));
    chk("y",       32'(a_y),     hist[2].href ? 32'(hist[2].y) : 0);
    chk("c_avg",   32'(a_c),     hist[2].href ? 32'(hist[2].c_avg) : 0);
    chk("c_dec",   32'(d_c),     hist[2].href ? 32'(hist[2].c_dec) : 0);
    chk("dec_href", 32'(d_href), 32'(hist[2].href));
  endtask

  initial begin
    // Leading idle
    add(idl(0)); add(idl(0));
    // 8-pixel line: U=10..80, V=100..114
    add(px(10, 100, 15, 10));   add(px(20, 102, 101, 102));
    add(px(30, 104, 35, 30));   add(px(40, 106, 105, 106));
    add(px(50, 108, 55, 50));   add(px(60, 110, 109, 110));
    add(px(70, 112, 75, 70));   add(px(80, 114, 113, 114));
    add(idl(0)); add(idl(0));
    // Rounding extremes
    add(px(8'h01, 8'hFF, 8'h02, 8'h01)); add(px(8'h02, 8'hFF, 8'hFF, 8'hFF));
    add(px(8'h00, 8'h10, 8'h00, 8'h00)); add(px(8'h00, 8'h13, 8'h12, 8'h13));
    add(idl(0));
    // 5-pixel line, 1-cycle gap, 3-pixel line, gap, single-pixel glitch
    add(px(4, 40, 6, 4));       add(px(8, 41, 41, 41));
    add(px(12, 42, 14, 12));    add(px(16, 43, 43, 43));
    add(px(200, 44, 200, 200));
    add(idl(0));
    add(px(9, 3, 8, 9));        add(px(6, 4, 4, 4));
    add(px(77, 50, 77, 77));
    add(idl(0));
    add(px(8'h33, 8'h44, 8'h33, 8'h33));
    add(idl(0)); add(idl(0));
    // Decimation reference line: U=1..8, V=11..18
    add(px(1, 11, 2, 1));       add(px(2, 12, 12, 12));
    add(px(3, 13, 4, 3));       add(px(4, 14, 14, 14));
    add(px(5, 15, 6, 5));       add(px(6, 16, 16, 16));
    add(px(7, 17, 8, 7));       add(px(8, 18, 18, 18));
    add(idl(0)); add(idl(0));
    // vsync pulse with href low
    add(idl(1)); add(idl(1)); add(idl(1)); add(idl(1));
    add(idl(0)); add(idl(0)); add(idl(0));

    rst_n = 1'b0;
    in_href = 0; in_vsync = 0; in_y = 0; in_u = 0; in_v = 0;
    clear_hist();
    #12;
    check_zero("reset");
    @(posedge pclk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < n_tv; i++) step(tv[i]);

    // Reset pulse at pixel 3 of a line in progress
    step(px(1, 2, 2, 1));
    step(px(3, 4, 3, 4));
    step(px(5, 6, 5, 5));
    in_u = 7; in_v = 8; in_y = 8'h77; in_href = 1'b1;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk); #1;
      check_zero("rst_hold");
    end
    rst_n = 1'b1;
    clear_hist();
    // Line continues after release and restarts on an even (U) pixel
    step(px(100, 7, 101, 100));
    step(px(101, 9, 8, 9));
    step(px(8'hF0, 8'h80, 8'hF1, 8'hF0));
    step(px(8'hF2, 8'h81, 8'h81, 8'h81));
    for (int i = 0; i < 4; i++) step(idl(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
